// File: rtl/m_pkg.sv
// ----------------------------------------------------------------------------
// m_pkg
//   Shared types for the 8-byte-word packet stream and the packet classifier.
//   - buffer_t           : result token attached to every egress beat
//   - packet_word_off_t  : word index inside a packet
//   - in_t / out_t       : ingress / egress beat formats
//   - sym_match_masked_t : one masked match rule
//   - ing_state_e        : ingress FSM states
//   - byte_expand()      : per-byte mask -> per-bit mask
// ----------------------------------------------------------------------------
package m_pkg;

    typedef logic [7:0] buffer_t;
    typedef logic [7:0] packet_word_off_t;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [15:0] length;
        logic [63:0] data;
    } in_t;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [15:0] length;
        logic [63:0] data;
        buffer_t     buffer;
    } out_t;

    typedef struct packed {
        logic             valid;
        packet_word_off_t off;
        logic [63:0]      match;
        logic [7:0]       mask;
        buffer_t          buffer;
    } sym_match_masked_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT  = 2'd1,
        DROP = 2'd2
    } ing_state_e;

    // Mask bit i enables comparison of data byte i.
    function automatic logic [63:0] byte_expand(input logic [7:0] m);
        logic [63:0] res;
        res = '0;
        for (int i = 0; i < 8; i++) begin
            res[8*i +: 8] = {8{m[i]}};
        end
        return res;
    endfunction

endpackage

// File: rtl/m_classifier_fifo.sv
// ----------------------------------------------------------------------------
// m_fifo
//   Synchronous FIFO, N entries (power of two, >= 2) of W bits, with
//   registered full/empty flags derived from an occupancy counter.
//   The head entry is presented combinationally on o_rdata and stays stable
//   until popped. A push on a full FIFO is taken only together with a pop.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_push, i_wdata write request and data
//   i_pop           read request (ignored when empty)
//   o_rdata         head entry
//   o_full, o_empty occupancy flags
// ----------------------------------------------------------------------------
module m_fifo #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(N);

    logic [W-1:0]  r_mem [N];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_cnt;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_cnt == (AW+1)'(N));
    assign o_empty = (r_cnt == '0);

    // Pop-then-push: a full FIFO accepts a write only in a cycle that frees a slot.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];

endmodule

// File: rtl/m_classifier.sv
// ----------------------------------------------------------------------------
// m_classifier
//   Packet classifier. Each ingress packet is buffered word by word while a
//   table of N_RULES masked rules is evaluated against it; when the packet's
//   last beat has been seen, a result token (buffer of the lowest-index rule
//   that hit, DEFAULT_BUFFER otherwise) is queued, and the packet is replayed
//   on the egress side with that token on every beat.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_vld, in, in_accept  ingress beat handshake
//   out_vld, out, out_accept egress beat handshake
//   cfg_vld, cfg_idx, cfg_rule  rule write into the shadow table
//   err_oversize           sticky, a packet exceeded DEPTH words
//   err_framing            sticky, sop/eop framing violation seen
// ----------------------------------------------------------------------------
module m_classifier
    import m_pkg::*;
#(
    parameter int      N_RULES        = 4,
    parameter int      DEPTH          = 16,
    parameter int      TAG_DEPTH      = 4,
    parameter buffer_t DEFAULT_BUFFER = 8'h00
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          in_vld,
    input  in_t                                           in,
    output logic                                          in_accept,
    output logic                                          out_vld,
    output out_t                                          out,
    input  logic                                          out_accept,
    input  logic                                          cfg_vld,
    input  logic [(N_RULES > 1 ? $clog2(N_RULES) : 1)-1:0] cfg_idx,
    input  sym_match_masked_t                             cfg_rule,
    output logic                                          err_oversize,
    output logic                                          err_framing
);

    localparam int IDX_W = (N_RULES > 1) ? $clog2(N_RULES) : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    ing_state_e        r_state;
    packet_word_off_t  r_wcnt;
    logic [N_RULES-1:0] r_hits;
    sym_match_masked_t r_shadow [N_RULES];
    sym_match_masked_t r_active [N_RULES];
    logic              r_err_ovs;
    logic              r_err_frm;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    sym_match_masked_t  w_rules [N_RULES];
    packet_word_off_t   w_word;
    logic [N_RULES-1:0] w_hit_now;
    logic [N_RULES-1:0] w_hits_final;
    buffer_t            w_tag;

    logic       w_acc;
    logic       w_dpush;
    logic       w_tpush;
    logic       w_sop_idle;
    logic       w_set_ovs;
    logic       w_set_frm;
    in_t        w_beat;
    ing_state_e w_nstate;

    logic    w_data_full;
    logic    w_data_empty;
    logic    w_tag_full;
    logic    w_tag_empty;
    in_t     w_head;
    buffer_t w_tag_head;
    logic    w_pop_data;
    logic    w_pop_tag;

    assign w_acc = in_vld & in_accept;

    // The sop beat in IDLE is matched against the shadow table because that
    // is exactly what gets copied into the active table on the same edge.
    always_comb begin
        for (int r = 0; r < N_RULES; r++) begin
            w_rules[r] = (r_state == IDLE) ? r_shadow[r] : r_active[r];
        end
    end

    assign w_word = (r_state == IDLE) ? '0 : r_wcnt;

    // The word counter never reaches DEPTH while matching (the packet is cut
    // at DEPTH-1), so rules with off >= DEPTH can never hit.
    always_comb begin
        for (int r = 0; r < N_RULES; r++) begin
            w_hit_now[r] = w_rules[r].valid
                         & (w_word == w_rules[r].off)
                         & (((in.data ^ w_rules[r].match)
                             & byte_expand(w_rules[r].mask)) == 64'd0);
        end
    end

    // Hits of the beat being accepted are folded in, so the eop beat counts.
    assign w_hits_final = (r_state == IDLE) ? w_hit_now : (r_hits | w_hit_now);

    // Lowest index wins: scan downward so the last assignment is the lowest hit.
    always_comb begin
        w_tag = DEFAULT_BUFFER;
        for (int r = N_RULES - 1; r >= 0; r--) begin
            if (w_hits_final[r]) w_tag = w_rules[r].buffer;
        end
    end

    // ------------------------------------------------------------------
    // Ingress FSM, combinational part
    // ------------------------------------------------------------------
    always_comb begin
        w_dpush    = 1'b0;
        w_tpush    = 1'b0;
        w_sop_idle = 1'b0;
        w_set_ovs  = 1'b0;
        w_set_frm  = 1'b0;
        w_beat     = in;
        w_nstate   = r_state;
        if (w_acc) begin
            case (r_state)
                IDLE: begin
                    if (in.sop) begin
                        w_dpush    = 1'b1;
                        w_sop_idle = 1'b1;
                        if (in.eop) w_tpush  = 1'b1;
                        else        w_nstate = PKT;
                    end else begin
                        w_set_frm = 1'b1;
                    end
                end
                PKT: begin
                    w_dpush    = 1'b1;
                    w_beat.sop = 1'b0;
                    if (in.sop) w_set_frm = 1'b1;
                    if (in.eop) begin
                        w_tpush  = 1'b1;
                        w_nstate = IDLE;
                    end else if (r_wcnt == packet_word_off_t'(DEPTH - 1)) begin
                        // Truncate: close the stored packet here, drop the rest.
                        w_beat.eop = 1'b1;
                        w_tpush    = 1'b1;
                        w_set_ovs  = 1'b1;
                        w_nstate   = DROP;
                    end
                end
                DROP: begin
                    if (in.eop) w_nstate = IDLE;
                end
                default: w_nstate = IDLE;
            endcase
        end
    end

    // Occupancy is checked without crediting a same-cycle pop, so the stall
    // may last one cycle longer than strictly needed. DROP writes nothing.
    assign in_accept = ~rst & ((r_state == DROP) | (~w_data_full & ~w_tag_full));

    // ------------------------------------------------------------------
    // Ingress FSM, sequential part
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_wcnt    <= '0;
            r_hits    <= '0;
            r_err_ovs <= 1'b0;
            r_err_frm <= 1'b0;
            for (int r = 0; r < N_RULES; r++) begin
                r_shadow[r] <= '0;
                r_active[r] <= '0;
            end
        end else begin
            r_state <= w_nstate;
            if (w_set_ovs) r_err_ovs <= 1'b1;
            if (w_set_frm) r_err_frm <= 1'b1;

            if (w_sop_idle) begin
                r_wcnt <= packet_word_off_t'(1);
                r_hits <= w_hit_now;
            end else if (w_acc && (r_state == PKT)) begin
                r_wcnt <= r_wcnt + 1'b1;
                r_hits <= r_hits | w_hit_now;
            end

            // Active takes the pre-write shadow, so a cfg write in the same
            // cycle as sop only applies from the following packet.
            for (int r = 0; r < N_RULES; r++) begin
                if (w_sop_idle) r_active[r] <= r_shadow[r];
                if (cfg_vld && (cfg_idx == IDX_W'(r))) r_shadow[r] <= cfg_rule;
            end
        end
    end

    assign err_oversize = r_err_ovs;
    assign err_framing  = r_err_frm;

    // ------------------------------------------------------------------
    // Buffers
    // ------------------------------------------------------------------
    m_fifo #(
        .W ($bits(in_t)),
        .N (DEPTH)
    ) u_data_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_dpush),
        .i_wdata (w_beat),
        .i_pop   (w_pop_data),
        .o_rdata (w_head),
        .o_full  (w_data_full),
        .o_empty (w_data_empty)
    );

    m_fifo #(
        .W ($bits(buffer_t)),
        .N (TAG_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_tpush),
        .i_wdata (w_tag),
        .i_pop   (w_pop_tag),
        .o_rdata (w_tag_head),
        .o_full  (w_tag_full),
        .o_empty (w_tag_empty)
    );

    // ------------------------------------------------------------------
    // Egress: only complete packets (those with a tag) are replayed.
    // ------------------------------------------------------------------
    assign out_vld    = ~w_tag_empty & ~w_data_empty;
    assign w_pop_data = out_vld & out_accept;
    assign w_pop_tag  = w_pop_data & w_head.eop;

    always_comb begin
        out        = '0;
        out.sop    = w_head.sop;
        out.eop    = w_head.eop;
        out.length = w_head.length;
        out.data   = w_head.data;
        out.buffer = w_tag_head;
    end

endmodule

// File: tb/tb_m_classifier.sv
// ----------------------------------------------------------------------------
// tb_m_classifier
//   Scoreboard bench for m_classifier: expected egress beats are queued as
//   packets are driven and compared as the DUT emits them.
// ----------------------------------------------------------------------------
module tb_m_classifier;
    import m_pkg::*;

    localparam int N_RULES   = 4;
    localparam int DEPTH     = 16;
    localparam int TAG_DEPTH = 4;
    localparam logic [63:0] R0_MATCH = 64'h1122334455667788;
    localparam logic [63:0] R12_MATCH = 64'h0BADF00D_12345678;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_vld;
    in_t               in_b;
    logic              in_accept;
    logic              out_vld;
    out_t              out_b;
    logic              out_accept;
    logic              cfg_vld;
    logic [1:0]        cfg_idx;
    sym_match_masked_t cfg_rule;
    logic              err_oversize;
    logic              err_framing;

    int   total = 0;
    int   bad   = 0;
    out_t sb[$];
    bit   mon_en = 1'b0;
    int   seq = 0;

    m_classifier #(
        .N_RULES        (N_RULES),
        .DEPTH          (DEPTH),
        .TAG_DEPTH      (TAG_DEPTH),
        .DEFAULT_BUFFER (8'h00)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_vld       (in_vld),
        .in           (in_b),
        .in_accept    (in_accept),
        .out_vld      (out_vld),
        .out          (out_b),
        .out_accept   (out_accept),
        .cfg_vld      (cfg_vld),
        .cfg_idx      (cfg_idx),
        .cfg_rule     (cfg_rule),
        .err_oversize (err_oversize),
        .err_framing  (err_framing)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Egress monitor: a beat seen valid+accepted at negedge transfers on the next posedge.
    always @(negedge clk) begin : mon
        out_t e;
        if (mon_en && out_vld && out_accept) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 64'(out_vld), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("out_sop", 64'(out_b.sop), 64'(e.sop));
                chk("out_eop", 64'(out_b.eop), 64'(e.eop));
                chk("out_len", 64'(out_b.length), 64'(e.length));
                chk("out_data", out_b.data, e.data);
                chk("out_buf", 64'(out_b.buffer), 64'(e.buffer));
            end
        end
    end

    task automatic cfg_write(input int idx, input logic [7:0] off, input logic [63:0] match,
                             input logic [7:0] mask, input logic [7:0] bufv);
        cfg_idx         = 2'(idx);
        cfg_rule        = '0;
        cfg_rule.valid  = 1'b1;
        cfg_rule.off    = off;
        cfg_rule.match  = match;
        cfg_rule.mask   = mask;
        cfg_rule.buffer = bufv;
        cfg_vld         = 1'b1;
        @(posedge clk); #1;
        cfg_vld = 1'b0;
    endtask

    task automatic drive_beat(input logic sop, input logic eop, input logic [15:0] len,
                              input logic [63:0] d);
        int n = 0;
        in_b.sop    = sop;
        in_b.eop    = eop;
        in_b.length = len;
        in_b.data   = d;
        in_vld      = 1'b1;
        @(negedge clk);
        while (!in_accept && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_accept) chk("in_accept_timeout", 64'(in_accept), 64'd1);
        @(posedge clk); #1;
        in_vld = 1'b0;
    endtask

    // Word hit_off carries hit_word; other words get a per-packet unique pattern.
    task automatic send_pkt(input int n, input int hit_off, input logic [63:0] hit_word,
                            input logic [7:0] ebuf, input bit mid_cfg);
        out_t        e;
        logic [63:0] d;
        seq++;
        for (int i = 0; i < n; i++) begin
            d = (i == hit_off) ? hit_word : {16'hD0D0, 16'(seq), 32'(i)};
            if (i < DEPTH) begin
                e        = '0;
                e.sop    = (i == 0);
                e.eop    = (i == n - 1) || (i == DEPTH - 1);
                e.length = 16'(n * 8);
                e.data   = d;
                e.buffer = ebuf;
                sb.push_back(e);
            end
            drive_beat(i == 0, i == n - 1, 16'(n * 8), d);
            if (mid_cfg && i == 0) cfg_write(0, 8'd1, R0_MATCH, 8'hFF, 8'h5A);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
        chk("drain_idle_vld", 64'(out_vld), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        in_vld     = 1'b0;
        in_b       = '0;
        out_accept = 1'b0;
        cfg_vld    = 1'b0;
        cfg_idx    = '0;
        cfg_rule   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_vld", 64'(out_vld), 64'd0);
        chk("rst_in_accept", 64'(in_accept), 64'd0);
        chk("rst_err_ovs", 64'(err_oversize), 64'd0);
        chk("rst_err_frm", 64'(err_framing), 64'd0);
        rst        = 1'b0;
        out_accept = 1'b1;
        mon_en     = 1'b1;
        #1;
        chk("post_rst_accept", 64'(in_accept), 64'd1);

        // Single exact rule, first beat one cycle after eop.
        cfg_write(0, 8'd1, R0_MATCH, 8'hFF, 8'hA5);
        send_pkt(3, 1, R0_MATCH, 8'hA5, 1'b0);
        chk("lat_out_vld", 64'(out_vld), 64'd1);
        chk("lat_out_sop", 64'(out_b.sop), 64'd1);
        wait_drain();

        // Two rules hit: lowest index wins. No hit: default token.
        cfg_write(1, 8'd2, R12_MATCH, 8'hFF, 8'h11);
        cfg_write(2, 8'd2, R12_MATCH, 8'hFF, 8'h22);
        send_pkt(4, 2, R12_MATCH, 8'h11, 1'b0);
        send_pkt(3, -1, 64'd0, 8'h00, 1'b0);
        wait_drain();

        // Partial byte mask: upper bytes ignored, low-byte mismatch misses.
        cfg_write(3, 8'd3, 64'hCAFEBABE_DEADBEEF, 8'h0F, 8'h33);
        send_pkt(5, 3, 64'h01234567_DEADBEEF, 8'h33, 1'b0);
        send_pkt(5, 3, 64'hCAFEBABE_DEADBEE0, 8'h00, 1'b0);
        wait_drain();

        // Rule rewrite mid-packet affects only the following packet.
        send_pkt(3, 1, R0_MATCH, 8'hA5, 1'b1);
        send_pkt(3, 1, R0_MATCH, 8'h5A, 1'b0);
        wait_drain();

        // Oversize packet is truncated to DEPTH words; next packets normal.
        chk("pre_err_ovs", 64'(err_oversize), 64'd0);
        send_pkt(20, 1, R0_MATCH, 8'h5A, 1'b0);
        chk("err_ovs", 64'(err_oversize), 64'd1);
        wait_drain();
        send_pkt(3, -1, 64'd0, 8'h00, 1'b0);
        send_pkt(2, 1, R0_MATCH, 8'h5A, 1'b0);
        wait_drain();
        chk("no_err_frm", 64'(err_framing), 64'd0);

        // Non-sop beat while idle is discarded and flagged.
        drive_beat(1'b0, 1'b1, 16'd8, 64'hFFFF_0000_FFFF_0000);
        chk("err_frm", 64'(err_framing), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("frm_no_out", 64'(out_vld), 64'd0);

        // Backpressure: tag FIFO full after TAG_DEPTH packets.
        out_accept = 1'b0;
        for (int p = 0; p < TAG_DEPTH; p++) send_pkt(2, -1, 64'd0, 8'h00, 1'b0);
        chk("bp_in_accept", 64'(in_accept), 64'd0);
        chk("bp_out_vld", 64'(out_vld), 64'd1);
        out_accept = 1'b1;
        wait_drain();

        // Reset mid-packet with a complete packet resident.
        out_accept = 1'b0;
        send_pkt(2, -1, 64'd0, 8'h00, 1'b0);
        drive_beat(1'b1, 1'b0, 16'd32, 64'h1);
        drive_beat(1'b0, 1'b0, 16'd32, 64'h2);
        chk("pre_rst_vld", 64'(out_vld), 64'd1);
        rst    = 1'b1;
        mon_en = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_vld", 64'(out_vld), 64'd0);
        chk("mid_rst_accept", 64'(in_accept), 64'd0);
        chk("mid_rst_ovs", 64'(err_oversize), 64'd0);
        chk("mid_rst_frm", 64'(err_framing), 64'd0);
        sb.delete();
        rst        = 1'b0;
        out_accept = 1'b1;
        mon_en     = 1'b1;
        #1;
        chk("post_rst2_accept", 64'(in_accept), 64'd1);
        // Rules were cleared by reset, so the old rule 0 pattern now misses.
        send_pkt(3, 1, R0_MATCH, 8'h00, 1'b0);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
